demux_1to4_buf: RTL and testbench



---
 rtl/demux_1to4_buf_if.sv | 25 ++
 rtl/demux_1to4_buf.sv | 95 +++++++++
 tb/tb_demux_1to4_buf.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_1to4_buf_if.sv
// Producer-side and consumer-side handshake bundle of the 1:4 buffered demux.
//   in_valid/in_ready/in_data     : single input stream (valid/ready)
//   out_valid/out_ready/out_data  : four output lanes, lane k in bit k / slice k
// master: drives the input stream and the lane ready bits (producer + consumers)
// slave : the demux itself
interface demux_1to4_buf_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [4*WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_1to4_buf.sv
// Registered 1:4 demultiplexer with a 1-deep valid/ready buffer and a
// saturating delivered-beat counter per output lane. The target lane is
// {s1,s0}, or an internal round-robin pointer when rr_en=1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : input stream + four output lanes (slave modport)
//   s0, s1    : manual lane select (rr_en=0)
//   rr_en     : route by round-robin pointer
//   cnt_clr   : synchronous clear of all beat counters (wins over increment)
//   rr_ptr    : current round-robin pointer
//   beat_cnt  : lane k delivered count in beat_cnt[k*CNT_W +: CNT_W]
module demux_1to4_buf #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1to4_buf_if.slave      bus,
  input  logic                 s0,
  input  logic                 s1,
  input  logic                 rr_en,
  input  logic                 cnt_clr,
  output logic [1:0]           rr_ptr,
  output logic [4*CNT_W-1:0]   beat_cnt
);

  localparam int unsigned NCH = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]             valid_q, valid_d;
  logic [NCH-1:0][WIDTH-1:0]  data_q,  data_d;
  logic [NCH-1:0][CNT_W-1:0]  cnt_q,   cnt_d;
  logic [1:0]                 ptr_q,   ptr_d;

  logic [1:0]     sel_c;
  logic           ready_c;
  logic           accept_c;
  logic [NCH-1:0] pop_c;

  // Handshake decode: a lane accepts when empty or being drained this cycle.
  always_comb begin
    sel_c    = rr_en ? ptr_q : {s1, s0};
    ready_c  = ~rst & (~valid_q[sel_c] | bus.out_ready[sel_c]);
    accept_c = bus.in_valid & ready_c;
    pop_c    = valid_q & bus.out_ready;
  end

  // Next-state for lane buffers, counters and the round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    for (int k = 0; k < NCH; k++) begin
      if (pop_c[k]) begin
        valid_d[k] = 1'b0;
      end
      // Same-cycle accept overrides the pop so the lane stays full.
      if (accept_c && (sel_c == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = bus.in_data;
      end
      if (cnt_clr) begin
        cnt_d[k] = '0;
      end else if (pop_c[k] && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    if (accept_c && rr_en) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign rr_ptr        = ptr_q;
  assign beat_cnt      = cnt_q;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: two instances (8-bit and 2-bit counters) share
// the same stimulus and are compared every cycle against a lane-level model.
module tb_demux_1to4_buf;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;
  logic s0, s1, rr_en, cnt_clr;
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic [3:0] out_ready;

  logic [1:0]  ptr_m, ptr_s;
  logic [31:0] cnt_m;
  logic [7:0]  cnt_s;

  demux_1to4_buf_if #(.WIDTH(WIDTH)) if_m ();
  demux_1to4_buf_if #(.WIDTH(WIDTH)) if_s ();

  assign if_m.in_valid  = in_valid;
  assign if_m.in_data   = in_data;
  assign if_m.out_ready = out_ready;
  assign if_s.in_valid  = in_valid;
  assign if_s.in_data   = in_data;
  assign if_s.out_ready = out_ready;

  demux_1to4_buf #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(if_m), .s0(s0), .s1(s1),
    .rr_en(rr_en), .cnt_clr(cnt_clr), .rr_ptr(ptr_m), .beat_cnt(cnt_m)
  );

  demux_1to4_buf #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(if_s), .s0(s0), .s1(s1),
    .rr_en(rr_en), .cnt_clr(cnt_clr), .rr_ptr(ptr_s), .beat_cnt(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane-level model: each lane is a one-slot holding buffer.
  bit         m_full [4];
  logic [3:0] m_data [4];
  int         m_ptr;
  int         m_pops [4];   // unbounded delivered count since last clear

  function automatic int target();
    return rr_en ? m_ptr : int'({s1, s0});
  endfunction

  function automatic bit model_ready();
    int t = target();
    if (rst) return 1'b0;
    return !m_full[t] || out_ready[t];
  endfunction

  task automatic model_step();
    bit acc;
    int t;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0; m_data[k] = '0; m_pops[k] = 0;
      end
      m_ptr = 0;
      return;
    end
    acc = in_valid && model_ready();
    t   = target();
    for (int k = 0; k < 4; k++) begin
      if (m_full[k] && out_ready[k]) begin
        m_full[k] = 0;
        m_pops[k]++;
      end
      if (cnt_clr) m_pops[k] = 0;
    end
    if (acc) begin
      m_full[t] = 1;
      m_data[t] = in_data;
      if (rr_en) m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  ev;
    logic [15:0] ed;
    logic [31:0] ecm;
    logic [7:0]  ecs;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = m_full[k];
      ed[k*4 +: 4]   = m_data[k];
      ecm[k*8 +: 8]  = 8'((m_pops[k] > 255) ? 255 : m_pops[k]);
      ecs[k*2 +: 2]  = 2'((m_pops[k] > 3) ? 3 : m_pops[k]);
    end
    check("out_valid", 64'(if_m.out_valid), 64'(ev));
    check("out_data",  64'(if_m.out_data),  64'(ed));
    check("rr_ptr",    64'(ptr_m),          64'(m_ptr));
    check("beat_cnt",  64'(cnt_m),          64'(ecm));
    check("sat_out_valid", 64'(if_s.out_valid), 64'(ev));
    check("sat_out_data",  64'(if_s.out_data),  64'(ed));
    check("sat_rr_ptr",    64'(ptr_s),          64'(m_ptr));
    check("sat_beat_cnt",  64'(cnt_s),          64'(ecs));
  endtask

  // One clock: inputs are set by the caller while clk is low.
  task automatic tick();
    #1;
    check("in_ready",     64'(if_m.in_ready), 64'(model_ready()));
    check("sat_in_ready", 64'(if_s.in_ready), 64'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [3:0] d, input logic [1:0] sel,
                        input bit rr, input logic [3:0] ordy);
    in_valid  = v;
    in_data   = d;
    {s1, s0}  = sel;
    rr_en     = rr;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0;
    set_in(0, 4'h0, 2'd0, 0, 4'h0);
    m_ptr = 0;
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0; m_data[k] = '0; m_pops[k] = 0;
    end
    @(negedge clk);

    // Reset held two cycles, then idle with reset released.
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_ready", 64'(if_m.in_ready), 64'd1);

    // Manual select to lane 2, stall on full lane, load while draining.
    set_in(1, 4'hA, 2'd2, 0, 4'h0); tick();
    check("ch2_valid", 64'(if_m.out_valid), 64'b0100);
    check("ch2_data_A", 64'(if_m.out_data[8 +: 4]), 64'hA);
    set_in(1, 4'hB, 2'd2, 0, 4'h0); tick(); tick();
    check("stall_ready", 64'(if_m.in_ready), 64'd0);
    set_in(1, 4'hB, 2'd2, 0, 4'b0100); tick();
    check("ch2_data_B", 64'(if_m.out_data[8 +: 4]), 64'hB);
    set_in(0, 4'h0, 2'd0, 0, 4'hF); tick();

    // Clear counters, then five round-robin beats back to back.
    cnt_clr = 1'b1; set_in(0, 4'h0, 2'd0, 0, 4'h0); tick(); cnt_clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_in(1, 4'(i), 2'd0, 1, 4'hF); tick();
    end
    set_in(0, 4'h0, 2'd0, 1, 4'hF); tick();
    check("rr_wrap_ptr", 64'(ptr_m), 64'd1);
    check("rr_ch0_cnt", 64'(cnt_m[7:0]), 64'd2);

    // Round-robin blocked by a full lane 1: pointer holds, no skip.
    set_in(1, 4'h7, 2'd0, 1, 4'h0); tick();          // lane 1 now full
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4'(8 + i), 2'd0, 1, 4'b1101); tick(); // lanes 2,3,0
    end
    set_in(1, 4'hC, 2'd0, 1, 4'b0000); tick(); tick();
    check("rr_hold_ptr", 64'(ptr_m), 64'd1);
    set_in(1, 4'hC, 2'd0, 1, 4'b0010); tick();
    check("rr_resume_ptr", 64'(ptr_m), 64'd2);
    check("rr_ch1_data", 64'(if_m.out_data[4 +: 4]), 64'hC);

    // Saturation of the 2-bit counter on lane 3, then clear beats a pop.
    cnt_clr = 1'b1; set_in(0, 4'h0, 2'd0, 0, 4'hF); tick(); cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(1, 4'(i), 2'd3, 0, 4'hF); tick();
    end
    check("sat_ch3", 64'(cnt_s[7:6]), 64'd3);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_over_pop", 64'(cnt_s[7:6]), 64'd0);

    // Reset while lanes 0,1,3 are full.
    set_in(1, 4'h1, 2'd0, 0, 4'h0); tick();
    set_in(1, 4'h2, 2'd1, 0, 4'h0); tick();
    set_in(1, 4'h3, 2'd3, 0, 4'h0); tick();
    check("pre_rst_valid", 64'(if_m.out_valid), 64'b1011);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_valid", 64'(if_m.out_valid), 64'd0);
    check("rst_cnt", 64'(cnt_m), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      set_in(bit'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom),
             bit'($urandom), 4'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
